arbiter5_ctrl: RTL and testbench

- 2:1 merge/arbiter node for the async NoC tree. It is the upward-path counterpart to the per-node decoder.
- Two child links compete for one parent link. Round-robin fairness selects a winner.
- The 1-bit winner id is sent on the S channel first, then the 9-bit packet on Out. This is the same S-then-data ordering the decoder uses.
- Clocked RTL body. The wrapper converts each valid/ready port pair to/from e1of2 channels via SEND_M_1ofN / RECV_M_1ofN.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arbiter5_ctrl_rr_pick2.sv | 16 +
 rtl/arbiter5_ctrl.sv | 110 +++++++++++
 tb/tb_arbiter5_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the NoC tree merge/decode nodes.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_S = 2'd1,
        SEND_D = 2'd2
    } state_t;

    localparam int unsigned PKT_W   = 9;
    localparam int unsigned ADDR_HI = 8;
    localparam int unsigned ADDR_LO = 5;

endpackage

// File: rtl/arbiter5_ctrl_rr_pick2.sv
// Two-input round-robin pick: a lone requester always wins, a tie goes to prio.
module rr_pick2 (
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic gnt_valid,
    output logic winner
);

    // Winner select; prio only matters when both children request.
    always_comb begin
        gnt_valid = valid0 | valid1;
        winner    = (valid0 & valid1) ? prio : valid1;
    end

endmodule

// File: rtl/arbiter5_ctrl.sv
// 2:1 merge node: grants one child, sends winner id on S, then the packet on Out.
module arbiter5_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned W     = PKT_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [W-1:0]     in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [W-1:0]     in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic             s_data,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t             state_q, state_d;
    logic               prio_q;
    logic               s_data_q;
    logic [W-1:0]       out_data_q;
    logic [CNT_W-1:0]   cnt0_q, cnt1_q;

    logic               gnt_valid;
    logic               winner;
    logic               capture;
    logic               count;

    rr_pick2 u_pick (
        .valid0    (in0_valid),
        .valid1    (in1_valid),
        .prio      (prio_q),
        .gnt_valid (gnt_valid),
        .winner    (winner)
    );

    // State register.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; ready in IDLE implies the transfer happens this edge.
    always_comb begin
        state_d   = state_q;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        s_valid   = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        count     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    in0_ready = ~winner;
                    in1_ready = winner;
                    capture   = 1'b1;
                    state_d   = SEND_S;
                end
            end
            SEND_S: begin
                s_valid = 1'b1;
                if (s_ready) state_d = SEND_D;
            end
            SEND_D: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    count   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet capture, priority flip and per-child counters (s_data_q remembers the winner).
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            prio_q     <= 1'b0;
            s_data_q   <= 1'b0;
            out_data_q <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            if (capture) begin
                out_data_q <= winner ? in1_data : in0_data;
                s_data_q   <= winner;
                prio_q     <= ~winner;
            end
            if (count) begin
                if (s_data_q) cnt1_q <= cnt1_q + CNT_W'(1);
                else          cnt0_q <= cnt0_q + CNT_W'(1);
            end
        end
    end

    assign s_data   = s_data_q;
    assign out_data = out_data_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_arbiter5_ctrl.sv
// Directed bench for arbiter5_ctrl: per-cycle vectors of inputs and expected outputs.
module tb_arbiter5_ctrl;

    logic        CLK = 1'b0;
    logic        _RESET = 1'b0;
    logic [8:0]  in0_data = '0, in1_data = '0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic        in0_ready, in1_ready;
    logic        s_data, s_valid;
    logic        s_ready = 1'b0;
    logic [8:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] cnt0, cnt1;

    // Narrow-counter instance for the wrap boundary.
    logic [8:0]  b_in1_data = 9'h055;
    logic        b_in1_valid = 1'b0;
    logic        b_in0_ready, b_in1_ready, b_s_data, b_s_valid, b_out_valid;
    logic [8:0]  b_out_data;
    logic [1:0]  b_cnt0, b_cnt1;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned hs = 0;

    always #5 CLK = ~CLK;

    arbiter5_ctrl #(.W(9), .CNT_W(16)) dut (
        .CLK(CLK), ._RESET(_RESET),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    arbiter5_ctrl #(.W(9), .CNT_W(2)) dut_b (
        .CLK(CLK), ._RESET(_RESET),
        .in0_data(9'h000), .in0_valid(1'b0), .in0_ready(b_in0_ready),
        .in1_data(b_in1_data), .in1_valid(b_in1_valid), .in1_ready(b_in1_ready),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(1'b1),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(1'b1),
        .cnt0(b_cnt0), .cnt1(b_cnt1)
    );

    typedef struct {
        logic        v0;
        logic [8:0]  d0;
        logic        v1;
        logic [8:0]  d1;
        logic        sr;
        logic        orr;
        logic        r0;
        logic        r1;
        logic        sv;
        logic        sd;
        logic        ov;
        logic [8:0]  od;
        logic [15:0] c0;
        logic [15:0] c1;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [8:0] d0,
                                input logic v1, input logic [8:0] d1,
                                input logic sr, input logic orr,
                                input logic r0, input logic r1, input logic sv,
                                input logic sd, input logic ov, input logic [8:0] od,
                                input logic [15:0] c0, input logic [15:0] c1);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.sr = sr; v.orr = orr;
        v.r0 = r0; v.r1 = r1; v.sv = sv; v.sd = sd; v.ov = ov; v.od = od;
        v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic compare(input vec_t v, input string name);
        logic [45:0] act, exp;
        act = {in0_ready, in1_ready, s_valid, s_data, out_valid, out_data, cnt0, cnt1};
        exp = {v.r0, v.r1, v.sv, v.sd, v.ov, v.od, v.c0, v.c1};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got rdy=%b%b sv=%b sd=%b ov=%b od=%h c0=%h c1=%h, expected rdy=%b%b sv=%b sd=%b ov=%b od=%h c0=%h c1=%h",
                      name, in0_ready, in1_ready, s_valid, s_data, out_valid, out_data, cnt0, cnt1,
                      v.r0, v.r1, v.sv, v.sd, v.ov, v.od, v.c0, v.c1);
    endtask

    // Drive one cycle's inputs away from the rising edge, then check outputs before that edge.
    task automatic step(input vec_t v, input string name);
        @(negedge CLK);
        in0_valid = v.v0; in0_data = v.d0;
        in1_valid = v.v1; in1_data = v.d1;
        s_ready = v.sr; out_ready = v.orr;
        #1;
        if (out_valid && out_ready) hs++;
        compare(v, name);
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
        s_ready = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge CLK);
        idle_inputs();
        #3 _RESET = 1'b0;
        #1 compare(mk(0,0,0,0,0,0, 0,0,0,0,0,9'h000,16'h0,16'h0), name);
        @(negedge CLK);
        _RESET = 1'b1;
    endtask

    vec_t tbl[$];
    int unsigned hs0;

    initial begin
        // Contention table: both children valid for six packets.
        for (int k = 0; k < 6; k++) begin
            logic        w, pw;
            logic [8:0]  d, pd;
            logic [15:0] c0, c1;
            w  = k[0];
            pw = (k == 0) ? 1'b0 : ~w;
            d  = w ? 9'h0AA : 9'h100;
            pd = (k == 0) ? 9'h000 : (pw ? 9'h0AA : 9'h100);
            c0 = 16'((k + 1) / 2);
            c1 = 16'(k / 2);
            tbl.push_back(mk(1,9'h100,1,9'h0AA,1,1, ~w,w,0,pw,0,pd,c0,c1));
            tbl.push_back(mk(1,9'h100,1,9'h0AA,1,1, 0,0,1,w,0,d,c0,c1));
            tbl.push_back(mk(1,9'h100,1,9'h0AA,1,1, 0,0,0,w,1,d,c0,c1));
        end
        tbl.push_back(mk(0,0,0,0,1,1, 0,0,0,1,0,9'h0AA,16'd3,16'd3));

        // Power-on reset.
        idle_inputs();
        repeat (2) @(negedge CLK);
        #1 compare(mk(0,0,0,0,0,0, 0,0,0,0,0,9'h000,16'h0,16'h0), "reset_state");
        @(negedge CLK);
        _RESET = 1'b1;

        // Reset while a captured packet waits in SEND_D.
        step(mk(1,9'h1A5,0,0,1,0, 1,0,0,0,0,9'h000,16'h0,16'h0), "e_req");
        step(mk(0,0,0,0,1,0, 0,0,1,0,0,9'h1A5,16'h0,16'h0), "e_s");
        step(mk(0,0,0,0,1,0, 0,0,0,0,1,9'h1A5,16'h0,16'h0), "e_d_hold");
        #3 _RESET = 1'b0;
        #1 compare(mk(0,0,0,0,1,0, 0,0,0,0,0,9'h000,16'h0,16'h0), "e_async_rst");
        @(negedge CLK);
        _RESET = 1'b1;
        step(mk(0,0,1,9'h0F3,1,1, 0,1,0,0,0,9'h000,16'h0,16'h0), "e_in1_req");
        step(mk(0,0,0,0,1,1, 0,0,1,1,0,9'h0F3,16'h0,16'h0), "e_in1_s");
        step(mk(0,0,0,0,1,1, 0,0,0,1,1,9'h0F3,16'h0,16'h0), "e_in1_d");
        step(mk(0,0,0,0,1,1, 0,0,0,1,0,9'h0F3,16'h0,16'h1), "e_idle");

        // Lone in0 requester, sinks always ready.
        step(mk(1,9'h123,0,0,1,1, 1,0,0,1,0,9'h0F3,16'h0,16'h1), "b_req");
        step(mk(0,0,0,0,1,1, 0,0,1,0,0,9'h123,16'h0,16'h1), "b_s");
        step(mk(0,0,0,0,1,1, 0,0,0,0,1,9'h123,16'h0,16'h1), "b_d");
        step(mk(0,0,0,0,1,1, 0,0,0,0,0,9'h123,16'h1,16'h1), "b_idle");

        // prio is 1 here; after reset the first contention must go to child 0.
        do_reset("rst_before_table");
        foreach (tbl[i]) step(tbl[i], $sformatf("rr_row%0d", i));

        // S back-pressure for 10 cycles, then Out back-pressure.
        step(mk(1,9'h0C3,1,9'h0AA,0,1, 1,0,0,1,0,9'h0AA,16'd3,16'd3), "c_req");
        for (int i = 0; i < 10; i++)
            step(mk(1,9'h0C3,1,9'h0AA,0,1, 0,0,1,0,0,9'h0C3,16'd3,16'd3), $sformatf("c_shold%0d", i));
        step(mk(1,9'h0C3,1,9'h0AA,1,0, 0,0,1,0,0,9'h0C3,16'd3,16'd3), "c_sgo");
        for (int i = 0; i < 3; i++)
            step(mk(1,9'h0C3,1,9'h0AA,1,0, 0,0,0,0,1,9'h0C3,16'd3,16'd3), $sformatf("c_dhold%0d", i));
        step(mk(1,9'h0C3,1,9'h0AA,1,1, 0,0,0,0,1,9'h0C3,16'd3,16'd3), "c_dgo");
        step(mk(0,0,0,0,1,1, 0,0,0,0,0,9'h0C3,16'd4,16'd3), "c_idle");

        // Both sinks tied high: Out follows S by one cycle, one Out transfer per packet.
        hs0 = hs;
        step(mk(0,0,1,9'h1FF,1,1, 0,1,0,0,0,9'h0C3,16'd4,16'd3), "d_req1");
        step(mk(0,0,1,9'h1FF,1,1, 0,0,1,1,0,9'h1FF,16'd4,16'd3), "d_s1");
        step(mk(0,0,1,9'h1FF,1,1, 0,0,0,1,1,9'h1FF,16'd4,16'd3), "d_d1");
        step(mk(0,0,1,9'h1FF,1,1, 0,1,0,1,0,9'h1FF,16'd4,16'd4), "d_req2");
        step(mk(0,0,1,9'h1FF,1,1, 0,0,1,1,0,9'h1FF,16'd4,16'd4), "d_s2");
        step(mk(0,0,0,0,1,1, 0,0,0,1,1,9'h1FF,16'd4,16'd4), "d_d2");
        step(mk(0,0,0,0,1,1, 0,0,0,1,0,9'h1FF,16'd4,16'd5), "d_idle");
        n_total++;
        if (hs - hs0 == 2) n_pass++;
        else $display("FAIL d_out_transfers: got %0d, expected 2", hs - hs0);

        // Counter wrap on the 2-bit instance: four in1 packets take cnt1 3 -> 0.
        @(negedge CLK);
        b_in1_valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            #1;
            if (i == 9) begin
                n_total++;
                if (b_cnt1 === 2'd3) n_pass++;
                else $display("FAIL wrap_pre: got cnt1=%0d, expected 3", b_cnt1);
            end
            if (i == 12) begin
                b_in1_valid = 1'b0;
                n_total++;
                if (b_cnt1 === 2'd0 && b_cnt0 === 2'd0) n_pass++;
                else $display("FAIL wrap_post: got cnt1=%0d cnt0=%0d, expected 0 0", b_cnt1, b_cnt0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
